sst_reg_engine: RTL and testbench

//  Save-state initiator for mapper register files: drives the SST bus (act/addr/we_reg/dato) and samples sst_di.

---
 rtl/sst_pkg.sv | 31 +++
 rtl/sst_reg_engine.sv | 201 ++++++++++++++++++++
 tb/tb_sst_reg_engine.sv | 370 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sst_pkg.sv
// Shared types and constants for the SST save/load register engine.
package sst_pkg;

    localparam int   SST_AW        = 8;
    localparam int   SST_IDX_ADDR  = 127;
    localparam logic SST_MODE_SAVE = 1'b0;
    localparam logic SST_MODE_LOAD = 1'b1;

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        SETTLE   = 4'd1,
        S_MEM    = 4'd2,
        L_MEM    = 4'd3,
        L_WR     = 4'd4,
        V_SETTLE = 4'd5,
        V_CMP    = 4'd6,
        NEXT     = 4'd7,
        FIN      = 4'd8
    } sst_state_t;

    // A pass is in progress in every state except IDLE and the FIN cycle.
    function automatic logic sst_is_busy_state(input sst_state_t s);
        return (s != IDLE) && (s != FIN);
    endfunction

    // The mapper index register is read-only, so it is never readback-checked.
    function automatic logic sst_cmp_addr(input logic [SST_AW-1:0] a);
        return a != SST_AW'(SST_IDX_ADDR);
    endfunction

endpackage

// File: rtl/sst_reg_engine.sv
// SST bus initiator: SAVE copies mapper registers 0..SST_LEN-1 into a byte-wide
// state memory, LOAD writes the state memory back into the mapper with each
// write committed on a cpu_m3 strobe.
// Optional feature macro: SST_VERIFY_EN adds a readback compare after every
// LOAD write and drives the sticky err flag; without it err is constant 0.
module sst_reg_engine
    import sst_pkg::*;
#(
    parameter int SST_LEN    = 128,
    parameter int SETTLE_CYC = 1
) (
    input  logic              clk,
    input  logic              map_rst_n,
    input  logic              start,
    input  logic              mode,
    output logic              busy,
    output logic              done,
    output logic              err,
    input  logic              cpu_m3,
    output logic              sst_act,
    output logic [SST_AW-1:0] sst_addr,
    output logic              sst_we_reg,
    output logic [7:0]        sst_dato,
    input  logic [7:0]        sst_di,
    output logic [SST_AW-1:0] mem_addr,
    output logic              mem_wr,
    output logic              mem_rd,
    output logic [7:0]        mem_dato,
    input  logic [7:0]        mem_dati,
    input  logic              mem_ack
);

    localparam logic [SST_AW-1:0] LAST_ADDR   = SST_AW'(SST_LEN - 1);
    localparam logic [3:0]        LAST_SETTLE = 4'(SETTLE_CYC - 1);

    sst_state_t        state_q, state_d;
    logic              mode_q, mode_d;
    logic [SST_AW-1:0] addr_q, addr_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [7:0]        sst_dato_q, sst_dato_d;
    logic [7:0]        mem_dato_q, mem_dato_d;
    logic              err_q, err_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              we_q, we_d;
    logic              mem_wr_q, mem_wr_d;
    logic              mem_rd_q, mem_rd_d;

    // Next-state, datapath and registered-output decode for the pass sequencer.
    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        sst_dato_d = sst_dato_q;
        mem_dato_d = mem_dato_q;
        err_d      = err_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SETTLE;
                    mode_d  = mode;
                    addr_d  = '0;
                    cnt_d   = 4'd0;
                    err_d   = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            SETTLE: begin
                if (cnt_q == LAST_SETTLE) begin
                    cnt_d = 4'd0;
                    if (mode_q == SST_MODE_SAVE) begin
                        mem_dato_d = sst_di;
                        state_d    = S_MEM;
                    end else begin
                        state_d = L_MEM;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_MEM: begin
                if (mem_ack) begin
                    state_d = NEXT;
                end else begin
                    state_d = S_MEM;
                end
            end
            L_MEM: begin
                if (mem_ack) begin
                    sst_dato_d = mem_dati;
                    state_d    = L_WR;
                end else begin
                    state_d = L_MEM;
                end
            end
            L_WR: begin
                // The mapper takes the write on the edge that sees cpu_m3 high.
                if (cpu_m3) begin
                    cnt_d = 4'd0;
`ifdef SST_VERIFY_EN
                    state_d = V_SETTLE;
`else
                    state_d = NEXT;
`endif
                end else begin
                    state_d = L_WR;
                end
            end
`ifdef SST_VERIFY_EN
            V_SETTLE: begin
                if (cnt_q == LAST_SETTLE) begin
                    cnt_d   = 4'd0;
                    state_d = V_CMP;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            V_CMP: begin
                if ((sst_di != sst_dato_q) && sst_cmp_addr(addr_q)) begin
                    err_d = 1'b1;
                end else begin
                    err_d = err_q;
                end
                state_d = NEXT;
            end
`endif
            NEXT: begin
                if (addr_q == LAST_ADDR) begin
                    state_d = FIN;
                end else begin
                    addr_d  = addr_q + SST_AW'(1);
                    cnt_d   = 4'd0;
                    state_d = SETTLE;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d   = sst_is_busy_state(state_d);
        done_d   = (state_d == FIN);
        we_d     = (state_d == L_WR) && (mode_d == SST_MODE_LOAD);
        mem_wr_d = (state_d == S_MEM);
        mem_rd_d = (state_d == L_MEM);
    end

    // State, counters and all bus outputs are registered; reset aborts any pass.
    always_ff @(posedge clk or negedge map_rst_n) begin
        if (!map_rst_n) begin
            state_q    <= IDLE;
            mode_q     <= 1'b0;
            addr_q     <= '0;
            cnt_q      <= 4'd0;
            sst_dato_q <= 8'd0;
            mem_dato_q <= 8'd0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            we_q       <= 1'b0;
            mem_wr_q   <= 1'b0;
            mem_rd_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            sst_dato_q <= sst_dato_d;
            mem_dato_q <= mem_dato_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            we_q       <= we_d;
            mem_wr_q   <= mem_wr_d;
            mem_rd_q   <= mem_rd_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign sst_act    = busy_q;
    assign sst_addr   = addr_q;
    assign mem_addr   = addr_q;
    assign sst_we_reg = we_q;
    assign sst_dato   = sst_dato_q;
    assign mem_wr     = mem_wr_q;
    assign mem_rd     = mem_rd_q;
    assign mem_dato   = mem_dato_q;
`ifdef SST_VERIFY_EN
    assign err        = err_q;
`else
    assign err        = 1'b0;
`endif

endmodule

// File: tb/tb_sst_reg_engine.sv
// Self-checking bench for sst_reg_engine: mapper and state-memory models,
// table-driven passes, randomized passes against a copy-semantics reference,
// and hand-written corner sequences. A second instance covers SST_LEN=1.
module tb_sst_reg_engine;

    localparam int LEN = 128;
`ifdef SST_VERIFY_EN
    localparam int LOAD_BYTE = 6;
    localparam logic EXP_ERR = 1'b1;
`else
    localparam int LOAD_BYTE = 4;
    localparam logic EXP_ERR = 1'b0;
`endif
    localparam int SAVE_BYTE = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       map_rst_n, start, mode, cpu_m3, mem_ack;
    logic [7:0] sst_di, mem_dati;
    logic       busy, done, err, sst_act, sst_we_reg, mem_wr, mem_rd;
    logic [7:0] sst_addr, sst_dato, mem_addr, mem_dato;

    logic       start2, busy2, done2, err2, act2, we2, mem_wr2, mem_rd2;
    logic [7:0] di2, addr2, dato2, mem_addr2, mem_dato2;
    logic       mode2 = 1'b0;
    logic       mem_ack2 = 1'b1;
    logic [7:0] mem_dati2 = 8'h00;

    sst_reg_engine #(.SST_LEN(128), .SETTLE_CYC(1)) u_dut (
        .clk(clk), .map_rst_n(map_rst_n), .start(start), .mode(mode),
        .busy(busy), .done(done), .err(err), .cpu_m3(cpu_m3),
        .sst_act(sst_act), .sst_addr(sst_addr), .sst_we_reg(sst_we_reg),
        .sst_dato(sst_dato), .sst_di(sst_di), .mem_addr(mem_addr),
        .mem_wr(mem_wr), .mem_rd(mem_rd), .mem_dato(mem_dato),
        .mem_dati(mem_dati), .mem_ack(mem_ack));

    sst_reg_engine #(.SST_LEN(1), .SETTLE_CYC(3)) u_one (
        .clk(clk), .map_rst_n(map_rst_n), .start(start2), .mode(mode2),
        .busy(busy2), .done(done2), .err(err2), .cpu_m3(cpu_m3),
        .sst_act(act2), .sst_addr(addr2), .sst_we_reg(we2),
        .sst_dato(dato2), .sst_di(di2), .mem_addr(mem_addr2),
        .mem_wr(mem_wr2), .mem_rd(mem_rd2), .mem_dato(mem_dato2),
        .mem_dati(mem_dati2), .mem_ack(mem_ack2));

    // Models: mapper registers and state memory
    logic [7:0] map_reg [256];
    logic [7:0] st_mem  [256];
    logic [7:0] map_init [256];
    logic [7:0] mem_init [256];
    int         ack_wait [256];
    int         commit_cnt [256];
    logic       load_req = 1'b0;
    int         drop_addr = -1;
    int         m3_per = 1;
    logic       ack_idle = 1'b0;
    logic       cur_mode = 1'b0;

    assign sst_di   = map_reg[sst_addr];
    assign mem_dati = st_mem[mem_addr];

    int   done_cnt = 0, busy_cyc = 0, viol = 0, wr3_cyc = 0;
    int   done2_cnt = 0, busy2_cyc = 0, viol2 = 0;
    logic [7:0] cap2 = 8'h00;
    logic [7:0] prev_addr = 8'h00, prev_mdato = 8'h00;
    logic prev_busy = 1'b0, prev_we = 1'b0, prev_m3 = 1'b0, prev_mwr = 1'b0;
    int   pend = 0, m3_ph = 0, n2 = 0;

    int nchk = 0;
    int nerr = 0;

    // Mapper commits, memory writes and protocol monitors on the active edge
    always @(posedge clk) begin
        if (load_req) begin
            for (int i = 0; i < 256; i++) begin
                map_reg[i] <= map_init[i];
                st_mem[i]  <= mem_init[i];
            end
        end else begin
            if (sst_act && sst_we_reg && cpu_m3) begin
                commit_cnt[sst_addr] <= commit_cnt[sst_addr] + 1;
                if (int'(sst_addr) != drop_addr) map_reg[sst_addr] <= sst_dato;
            end
            if (mem_wr && mem_ack) st_mem[mem_addr] <= mem_dato;
        end
        done_cnt <= done_cnt + int'(done);
        busy_cyc <= busy_cyc + int'(busy);
        wr3_cyc  <= wr3_cyc + int'(mem_wr && mem_addr == 8'd3);
        viol <= viol + int'(mem_wr && mem_rd)
                     + int'(sst_we_reg && cur_mode == 1'b0)
                     + int'(mem_addr != sst_addr)
                     + int'(busy && prev_busy && sst_addr != prev_addr && sst_addr != prev_addr + 8'd1)
                     + int'(sst_we_reg && prev_we && prev_m3)
                     + int'(prev_we && !prev_m3 && !sst_we_reg && busy)
                     + int'(mem_wr && prev_mwr && mem_dato != prev_mdato)
                     + int'(done && busy);
        prev_addr  <= sst_addr;
        prev_busy  <= busy;
        prev_we    <= sst_we_reg;
        prev_m3    <= cpu_m3;
        prev_mwr   <= mem_wr;
        prev_mdato <= mem_dato;
        done2_cnt <= done2_cnt + int'(done2);
        busy2_cyc <= busy2_cyc + int'(busy2);
        if (mem_wr2 && mem_ack2) cap2 <= mem_dato2;
        viol2 <= viol2 + int'(mem_rd2) + int'(we2) + int'(err2)
                       + int'(mem_addr2 != addr2) + int'(dato2 != 8'h00);
    end

    // Memory acknowledge, cpu_m3 strobe and the one-byte mapper data ramp
    always @(negedge clk) begin
        if (mem_wr || mem_rd) begin
            mem_ack <= (pend >= ack_wait[mem_addr]);
            pend    <= pend + 1;
        end else begin
            mem_ack <= ack_idle;
            pend    <= 0;
        end
        m3_ph <= m3_ph + 1;
        if (m3_per == 0) cpu_m3 <= 1'b0;
        else             cpu_m3 <= ((m3_ph % m3_per) == 0);
        if (act2) begin
            di2 <= 8'h31 + 8'(n2);
            n2  <= n2 + 1;
        end else begin
            di2 <= 8'h30;
            n2  <= 0;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic prep();
        @(negedge clk); load_req = 1'b1;
        @(negedge clk); load_req = 1'b0;
    endtask

    task automatic wait_done(input int d0, input int budget);
        int n = 0;
        while (done_cnt == d0 && n < budget) begin @(negedge clk); n++; end
        repeat (2) @(negedge clk);
    endtask

    task automatic run_pass(input logic m, input int budget, output int cyc, output int dn);
        int d0, b0;
        d0 = done_cnt; b0 = busy_cyc;
        cur_mode = m;
        @(negedge clk); start = 1'b1; mode = m;
        @(negedge clk); start = 1'b0;
        wait_done(d0, budget);
        cyc = busy_cyc - b0;
        dn  = done_cnt - d0;
    endtask

    // Reference: SAVE copies mapper -> memory for 0..LEN-1, LOAD copies memory -> mapper.
    task automatic chk_data(input string name, input logic m);
        int bad = 0;
        logic [7:0] em, ep;
        for (int i = 0; i < 256; i++) begin
            em = mem_init[i];
            ep = map_init[i];
            if (i < LEN) begin
                if (m == 1'b0) em = map_init[i];
                else if (i != drop_addr) ep = mem_init[i];
            end
            if (st_mem[i] !== em) bad++;
            if (map_reg[i] !== ep) bad++;
        end
        chk(name, bad, 0);
    endtask

    typedef struct {
        logic m;
        int   ack_w;
        logic idle_ack;
        int   m3p;
        int   exp_busy;
        int   exp_done;
    } vec_t;

    initial begin
        vec_t vt[4];
        int cyc, dn, v0, w0, d0, n, bad;
        int c0 [256];

        vt[0] = '{1'b0, 0, 1'b0, 1, LEN * SAVE_BYTE, 1};
        vt[1] = '{1'b0, 2, 1'b1, 1, LEN * (SAVE_BYTE + 2), 1};
        vt[2] = '{1'b1, 0, 1'b0, 1, LEN * LOAD_BYTE, 1};
        vt[3] = '{1'b1, 1, 1'b1, 1, LEN * (LOAD_BYTE + 1), 1};

        start = 1'b0; mode = 1'b0; start2 = 1'b0;
        for (int i = 0; i < 256; i++) ack_wait[i] = 0;
        map_rst_n = 1'b1;
        #2 map_rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ctl", {busy, done, err, sst_act, sst_we_reg, mem_wr, mem_rd}, 7'd0);
        chk("rst_addr", {sst_addr, mem_addr}, 16'd0);
        chk("rst_data", {sst_dato, mem_dato}, 16'd0);
        map_rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Table-driven passes with fixed ack latency and continuous cpu_m3
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 256; i++) begin
                ack_wait[i] = vt[r].ack_w;
                map_init[i] = 8'($urandom_range(255));
                mem_init[i] = 8'($urandom_range(255));
            end
            ack_idle = vt[r].idle_ack;
            m3_per   = vt[r].m3p;
            prep();
            v0 = viol;
            run_pass(vt[r].m, 4000, cyc, dn);
            chk($sformatf("tbl%0d_busy_cycles", r), cyc, vt[r].exp_busy);
            chk($sformatf("tbl%0d_done", r), dn, vt[r].exp_done);
            chk_data($sformatf("tbl%0d_data", r), vt[r].m);
            chk($sformatf("tbl%0d_protocol", r), viol - v0, 0);
        end
        ack_idle = 1'b0;

        // Randomized passes: random mode, per-address ack latency, strobe rate
        for (int r = 0; r < 6; r++) begin
            logic m;
            m = 1'($urandom_range(1));
            m3_per = $urandom_range(4, 1);
            for (int i = 0; i < 256; i++) begin
                ack_wait[i] = $urandom_range(2);
                map_init[i] = 8'($urandom_range(255));
                mem_init[i] = 8'($urandom_range(255));
            end
            prep();
            v0 = viol;
            run_pass(m, 6000, cyc, dn);
            chk($sformatf("rnd%0d_done", r), dn, 1);
            chk_data($sformatf("rnd%0d_data", r), m);
            chk($sformatf("rnd%0d_protocol", r), viol - v0, 0);
        end

        // SAVE of known mapper contents with a 5-cycle memory ack on addr 3
        m3_per = 1;
        for (int i = 0; i < 256; i++) begin
            ack_wait[i] = 0;
            map_init[i] = 8'hFF;
            mem_init[i] = 8'h00;
        end
        for (int i = 0; i <= 10; i++) map_init[i] = 8'h10 + 8'(i);
        map_init[127] = 8'h04;
        ack_wait[3] = 4;
        prep();
        v0 = viol; w0 = wr3_cyc;
        run_pass(1'b0, 4000, cyc, dn);
        chk("save_mem0", st_mem[0], 8'h10);
        chk("save_mem10", st_mem[10], 8'h1A);
        chk("save_mem11", st_mem[11], 8'hFF);
        chk("save_mem127", st_mem[127], 8'h04);
        chk("save_mem128_untouched", st_mem[128], 8'h00);
        chk("save_done", dn, 1);
        chk("save_busy_cycles", cyc, LEN * SAVE_BYTE + 4);
        chk("ack_delay_wr_hold", wr3_cyc - w0, 5);
        chk("ack_delay_protocol", viol - v0, 0);
        ack_wait[3] = 0;

        // LOAD with cpu_m3 one cycle in four
        m3_per = 4;
        for (int i = 0; i < 256; i++) begin
            map_init[i] = 8'hEE;
            mem_init[i] = 8'($urandom_range(255));
            c0[i] = commit_cnt[i];
        end
        mem_init[9] = 8'h01;
        prep();
        v0 = viol;
        run_pass(1'b1, 8000, cyc, dn);
        chk("load_reg9", map_reg[9], 8'h01);
        chk("load_commit9", commit_cnt[9] - c0[9], 1);
        bad = 0;
        for (int i = 0; i < 256; i++) begin
            if (commit_cnt[i] - c0[i] != ((i < LEN) ? 1 : 0)) bad++;
        end
        chk("load_one_commit_each", bad, 0);
        chk_data("load_m3_data", 1'b1);
        chk("load_m3_protocol", viol - v0, 0);

        // cpu_m3 stuck low stalls the first write indefinitely
        m3_per = 0;
        prep();
        cur_mode = 1'b1;
        d0 = done_cnt;
        @(negedge clk); start = 1'b1; mode = 1'b1;
        @(negedge clk); start = 1'b0;
        n = 0;
        while (!sst_we_reg && n < 20) begin @(negedge clk); n++; end
        chk("stuck_reach_wr", sst_we_reg, 1'b1);
        repeat (30) @(negedge clk);
        chk("stuck_hold", {sst_we_reg, busy, sst_addr}, {1'b1, 1'b1, 8'd0});
        m3_per = 1;
        wait_done(d0, 4000);
        chk("stuck_release_done", done_cnt - d0, 1);

        // start while busy is ignored, then reset mid-pass at addr 40
        cur_mode = 1'b0;
        @(negedge clk); start = 1'b1; mode = 1'b0;
        @(negedge clk); start = 1'b0;
        n = 0;
        while (sst_addr != 8'd40 && n < 600) begin @(negedge clk); n++; end
        chk("busy_reach_addr40", sst_addr, 8'd40);
        start = 1'b1; mode = 1'b1;
        @(negedge clk); start = 1'b0; mode = 1'b0;
        @(negedge clk);
        chk("start_ignored_addr", sst_addr >= 8'd40, 1'b1);
        chk("start_ignored_busy", busy, 1'b1);
        d0 = done_cnt;
        map_rst_n = 1'b0;
        #1;
        chk("midrst_outputs", {busy, done, err, sst_act, sst_we_reg, mem_wr, mem_rd,
                                sst_addr, mem_addr, sst_dato, mem_dato}, 39'd0);
        repeat (3) @(negedge clk);
        map_rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("midrst_no_done", done_cnt - d0, 0);
        chk("midrst_idle", busy, 1'b0);

        // Readback verify: mapper drops writes to addr 2
        drop_addr = 2;
        for (int i = 0; i < 256; i++) begin
            map_init[i] = 8'h00;
            mem_init[i] = 8'h40 + 8'(i);
        end
        prep();
        run_pass(1'b1, 4000, cyc, dn);
        chk("verify_done", dn, 1);
        chk("verify_err", err, EXP_ERR);
        chk_data("verify_data", 1'b1);
        drop_addr = -1;
        cur_mode = 1'b0;
        d0 = done_cnt;
        @(negedge clk); start = 1'b1; mode = 1'b0;
        @(negedge clk); start = 1'b0;
        chk("verify_err_cleared", err, 1'b0);
        wait_done(d0, 4000);

        // SST_LEN=1, SETTLE_CYC=3 instance
        d0 = done2_cnt; v0 = busy2_cyc;
        @(negedge clk); start2 = 1'b1;
        @(negedge clk); start2 = 1'b0;
        n = 0;
        while (done2_cnt == d0 && n < 50) begin @(negedge clk); n++; end
        repeat (4) @(negedge clk);
        chk("one_sample_time", cap2, 8'h33);
        chk("one_done_once", done2_cnt - d0, 1);
        chk("one_busy_cycles", busy2_cyc - v0, 5);
        chk("one_protocol", viol2, 0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", nchk, nerr);
        $fatal(1);
    end

endmodule
